cuckoo_ctrl: RTL and testbench

//  Sequencing controller for the two-table cuckoo hash store. It owns table1/table2 and their filled bits.
//  It serialises INSERT/LOOKUP/DELETE/CLEAR requests over a valid/ready port and runs the eviction
//  (kick) loop for inserts, bounded by MAX_KICKS. Sits between the top-level request source and storage.

---
 rtl/cuckoo_pkg.sv | 19 +
 rtl/cuckoo_hash.sv | 18 +
 rtl/cuckoo_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cuckoo_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cuckoo_pkg.sv
// Shared encodings for the cuckoo hash controller: request opcodes and FSM states.
package cuckoo_pkg;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_LOOKUP = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROBE = 3'd1,
        S_KICK1 = 3'd2,
        S_KICK2 = 3'd3,
        S_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/cuckoo_hash.sv
// Combinational hash pair: h1 = k mod N, h2 = (k div N) mod N, unsigned.
module cuckoo_hash #(
    parameter int TABLE_SIZE = 20,
    parameter int KEY_W      = 32,
    localparam int IDX_W     = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1
) (
    input  logic [KEY_W-1:0] i_key,
    output logic [IDX_W-1:0] o_h1,
    output logic [IDX_W-1:0] o_h2
);

    localparam logic [KEY_W-1:0] SIZE_K = KEY_W'(TABLE_SIZE);

    // Both results are below TABLE_SIZE, so truncation to IDX_W loses nothing.
    assign o_h1 = IDX_W'(i_key % SIZE_K);
    assign o_h2 = IDX_W'((i_key / SIZE_K) % SIZE_K);

endmodule

// File: rtl/cuckoo_ctrl.sv
// Two-table cuckoo hash controller: serialises INSERT/LOOKUP/DELETE/CLEAR and runs
// the bounded eviction loop. MAX_KICKS must fit in CNT_W bits.
module cuckoo_ctrl
    import cuckoo_pkg::*;
#(
    parameter int TABLE_SIZE = 20,
    parameter int KEY_W      = 32,
    parameter int MAX_KICKS  = 16,
    localparam int CNT_W     = $clog2(2*TABLE_SIZE+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [KEY_W-1:0] req_key,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_fail,
    output logic [KEY_W-1:0] resp_key,
    output logic [CNT_W-1:0] resp_kicks,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;

    logic [KEY_W-1:0] table1        [0:TABLE_SIZE-1];
    logic [KEY_W-1:0] table2        [0:TABLE_SIZE-1];
    logic             table1_filled [0:TABLE_SIZE-1];
    logic             table2_filled [0:TABLE_SIZE-1];

    state_e           r_state, w_state_next;
    op_e              r_op;
    logic [KEY_W-1:0] r_cur_key, r_req_key, r_resp_key;
    logic [CNT_W-1:0] r_kicks, r_count, r_resp_kicks;
    logic             r_resp_hit, r_resp_fail;

    logic [IDX_W-1:0] w_h1, w_h2;
    logic [KEY_W-1:0] w_evict;
    logic             w_hit1, w_hit2, w_present, w_last, w_accept;
    logic             w_wr1, w_wr2, w_del1, w_del2, w_clr_all;
    logic             w_inc, w_dec, w_swap, w_done, w_hit, w_fail;

    cuckoo_hash #(.TABLE_SIZE(TABLE_SIZE), .KEY_W(KEY_W)) u_hash (
        .i_key (r_cur_key),
        .o_h1  (w_h1),
        .o_h2  (w_h2)
    );

    assign w_hit1    = table1_filled[w_h1] && (table1[w_h1] == r_cur_key);
    assign w_hit2    = table2_filled[w_h2] && (table2[w_h2] == r_cur_key);
    assign w_present = w_hit1 || w_hit2;
    // A swap in this cycle makes kicks reach MAX_KICKS: the evicted key is dropped.
    assign w_last    = (r_kicks == CNT_W'(MAX_KICKS - 1));
    assign w_evict   = w_wr1 ? table1[w_h1] : table2[w_h2];
    assign w_accept  = (r_state == S_IDLE) && req_valid;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_hit   = r_resp_hit;
    assign resp_fail  = r_resp_fail;
    assign resp_key   = r_resp_key;
    assign resp_kicks = r_resp_kicks;
    assign count      = r_count;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state and per-cycle table/counter commands.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_wr1 = 1'b0; w_wr2 = 1'b0; w_del1 = 1'b0; w_del2 = 1'b0; w_clr_all = 1'b0;
        w_inc = 1'b0; w_dec = 1'b0; w_swap = 1'b0; w_done = 1'b0; w_hit = 1'b0; w_fail = 1'b0;
        case (r_state)
            S_IDLE: if (req_valid) w_state_next = S_PROBE;
            S_PROBE: begin
                w_state_next = S_RESP;
                w_done       = 1'b1;
                case (r_op)
                    OP_LOOKUP: w_hit = w_present;
                    OP_DELETE: begin
                        w_hit  = w_present;
                        w_del1 = w_hit1;
                        w_del2 = w_hit2;
                        w_dec  = w_present;
                    end
                    OP_CLEAR: w_clr_all = 1'b1;
                    default: begin
                        if (w_present) begin
                            w_hit = 1'b1;
                        end else if (!table1_filled[w_h1]) begin
                            w_wr1 = 1'b1;
                            w_inc = 1'b1;
                        end else if (!table2_filled[w_h2]) begin
                            w_wr2 = 1'b1;
                            w_inc = 1'b1;
                        end else begin
                            w_wr1        = 1'b1;
                            w_swap       = 1'b1;
                            w_fail       = w_last;
                            w_done       = w_last;
                            w_state_next = w_last ? S_RESP : S_KICK2;
                        end
                    end
                endcase
            end
            S_KICK2: begin
                w_wr2 = 1'b1;
                if (!table2_filled[w_h2]) begin
                    w_inc        = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_swap       = 1'b1;
                    w_fail       = w_last;
                    w_done       = w_last;
                    w_state_next = w_last ? S_RESP : S_KICK1;
                end
            end
            S_KICK1: begin
                w_wr1 = 1'b1;
                if (!table1_filled[w_h1]) begin
                    w_inc        = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_swap       = 1'b1;
                    w_fail       = w_last;
                    w_done       = w_last;
                    w_state_next = w_last ? S_RESP : S_KICK2;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request latch, kick loop key/counter, occupancy and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op         <= OP_INSERT;
            r_cur_key    <= '0;
            r_req_key    <= '0;
            r_kicks      <= '0;
            r_count      <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_fail  <= 1'b0;
            r_resp_key   <= '0;
            r_resp_kicks <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= op_e'(req_op);
                r_req_key <= req_key;
                r_cur_key <= req_key;
                r_kicks   <= '0;
            end
            if (w_swap) begin
                r_cur_key <= w_evict;
                r_kicks   <= r_kicks + 1'b1;
            end
            if (w_clr_all)  r_count <= '0;
            else if (w_inc) r_count <= r_count + 1'b1;
            else if (w_dec) r_count <= r_count - 1'b1;
            if (w_done) begin
                r_resp_hit   <= w_hit;
                r_resp_fail  <= w_fail;
                r_resp_key   <= w_fail ? w_evict : r_req_key;
                r_resp_kicks <= w_swap ? (r_kicks + 1'b1) : r_kicks;
            end
        end
    end

    // Filled bits: cleared by reset and CLEAR, set on write, dropped on DELETE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                table1_filled[i] <= 1'b0;
                table2_filled[i] <= 1'b0;
            end
        end else if (w_clr_all) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                table1_filled[i] <= 1'b0;
                table2_filled[i] <= 1'b0;
            end
        end else begin
            if (w_wr1)  table1_filled[w_h1] <= 1'b1;
            if (w_del1) table1_filled[w_h1] <= 1'b0;
            if (w_wr2)  table2_filled[w_h2] <= 1'b1;
            if (w_del2) table2_filled[w_h2] <= 1'b0;
        end
    end

    // Key storage writes; a swap writes cur_key while the old entry is read out combinationally.
    always_ff @(posedge clk) begin
        // NOTE: key storage has no reset; filled bits alone decide validity, so stale data is harmless.
        if (w_wr1) table1[w_h1] <= r_cur_key;
        if (w_wr2) table2[w_h2] <= r_cur_key;
    end

endmodule

// File: tb/tb_cuckoo_ctrl.sv
// Scoreboard bench for cuckoo_ctrl: directed scenarios, mid-kick reset, randomized ops
// against an array-based reference model, CLEAR and held-valid handshakes.
module tb_cuckoo_ctrl;

    localparam int TS = 11;
    localparam int KW = 32;
    localparam int MK = 4;
    localparam int CW = $clog2(2*TS+1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [KW-1:0] req_key = '0;
    logic          resp_valid, resp_hit, resp_fail;
    logic [KW-1:0] resp_key;
    logic [CW-1:0] resp_kicks, count;

    cuckoo_ctrl #(.TABLE_SIZE(TS), .KEY_W(KW), .MAX_KICKS(MK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_key    (req_key),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_fail  (resp_fail),
        .resp_key   (resp_key),
        .resp_kicks (resp_kicks),
        .count      (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0, n_resp = 0, n_issued = 0;

    // lat = clock edges from the accepting edge to the edge that raises resp_valid:
    // 1 for a plain op, 1+s for an insert placed after s swaps, MAX_KICKS on failure.
    typedef struct {
        logic          hit;
        logic          fail;
        logic [KW-1:0] key;
        int            kicks;
        int            cnt;
        int            lat;
        int            acc;
    } exp_t;
    exp_t sb[$];

    logic [KW-1:0] mt1 [TS];
    logic [KW-1:0] mt2 [TS];
    bit            mf1 [TS];
    bit            mf2 [TS];
    int            mcnt = 0;

    function automatic int h1(input logic [KW-1:0] k);
        return int'(k % KW'(TS));
    endfunction

    function automatic int h2(input logic [KW-1:0] k);
        return int'((k / KW'(TS)) % KW'(TS));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TS; i++) begin
            mf1[i] = 1'b0;
            mf2[i] = 1'b0;
        end
        mcnt = 0;
    endfunction

    // Cuckoo hashing rules applied directly to the model arrays.
    function automatic exp_t model_op(input logic [1:0] op, input logic [KW-1:0] key);
        exp_t          e;
        bit            in1, in2, placed;
        logic [KW-1:0] cur, old;
        int            tbl, idx;
        e.hit = 1'b0; e.fail = 1'b0; e.key = key; e.kicks = 0; e.lat = 1; e.acc = 0;
        in1 = mf1[h1(key)] && (mt1[h1(key)] == key);
        in2 = mf2[h2(key)] && (mt2[h2(key)] == key);
        case (op)
            2'd0: begin
                if (in1 || in2) begin
                    e.hit = 1'b1;
                end else if (!mf1[h1(key)]) begin
                    mt1[h1(key)] = key; mf1[h1(key)] = 1'b1; mcnt++;
                end else if (!mf2[h2(key)]) begin
                    mt2[h2(key)] = key; mf2[h2(key)] = 1'b1; mcnt++;
                end else begin
                    cur = key; tbl = 1; placed = 1'b0;
                    for (int s = 1; s <= MK && !placed && !e.fail; s++) begin
                        idx = (tbl == 1) ? h1(cur) : h2(cur);
                        if (tbl == 1) begin old = mt1[idx]; mt1[idx] = cur; end
                        else          begin old = mt2[idx]; mt2[idx] = cur; end
                        cur = old;
                        e.kicks = s;
                        if (s == MK) begin
                            e.fail = 1'b1; e.key = cur; e.lat = s;
                        end else begin
                            tbl = 3 - tbl;
                            idx = (tbl == 1) ? h1(cur) : h2(cur);
                            if (tbl == 1 && !mf1[idx]) begin
                                mt1[idx] = cur; mf1[idx] = 1'b1; placed = 1'b1;
                            end else if (tbl == 2 && !mf2[idx]) begin
                                mt2[idx] = cur; mf2[idx] = 1'b1; placed = 1'b1;
                            end
                            if (placed) begin mcnt++; e.lat = s + 1; end
                        end
                    end
                end
            end
            2'd1: e.hit = in1 || in2;
            2'd2: begin
                e.hit = in1 || in2;
                if (in1) mf1[h1(key)] = 1'b0;
                if (in2) mf2[h2(key)] = 1'b0;
                if (in1 || in2) mcnt--;
            end
            default: model_reset();
        endcase
        e.cnt = mcnt;
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Monitor: pops one expectation per response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && resp_valid) begin
                n_resp++;
                if (sb.size() == 0) begin
                    flag("unexpected_resp");
                end else begin
                    e = sb.pop_front();
                    check("resp_hit",   resp_hit,   e.hit);
                    check("resp_fail",  resp_fail,  e.fail);
                    check("resp_key",   resp_key,   e.key);
                    check("resp_kicks", resp_kicks, e.kicks);
                    check("count",      count,      e.cnt);
                    check("latency",    cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Drive one request; with hold=1 req_valid stays high until the response pulse.
    task automatic issue(input logic [1:0] op, input logic [KW-1:0] key, input bit hold);
        int   b;
        exp_t e;
        @(negedge clk);
        req_op = op; req_key = key; req_valid = 1'b1;
        b = 0;
        while (!req_ready && b < 100) begin @(negedge clk); b++; end
        if (!req_ready) begin flag("ready_timeout"); req_valid = 1'b0; return; end
        e = model_op(op, key);
        e.acc = cyc + 1;
        sb.push_back(e);
        n_issued++;
        @(posedge clk); #1;
        if (hold) begin
            b = 0;
            while (!resp_valid && b < 100) begin @(posedge clk); #1; b++; end
            if (!resp_valid) flag("hold_timeout");
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while ((sb.size() != 0 || !req_ready) && b < 300) begin @(negedge clk); b++; end
        if (sb.size() != 0 || !req_ready) flag(name);
    endtask

    task automatic check_all_empty(input string name);
        for (int i = 0; i < TS; i++) begin
            check($sformatf("%s_f1[%0d]", name, i), dut.table1_filled[i], 0);
            check($sformatf("%s_f2[%0d]", name, i), dut.table2_filled[i], 0);
        end
    endtask

    task automatic check_tables();
        for (int i = 0; i < TS; i++) begin
            check($sformatf("f1[%0d]", i), dut.table1_filled[i], mf1[i]);
            check($sformatf("f2[%0d]", i), dut.table2_filled[i], mf2[i]);
            if (mf1[i]) check($sformatf("t1[%0d]", i), dut.table1[i], mt1[i]);
            if (mf2[i]) check($sformatf("t2[%0d]", i), dut.table2[i], mt2[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_count", count, 0);
        check("rst_resp_valid", resp_valid, 0);
        check_all_empty("rst");
        reset_n = 1'b1;

        // Directed scenario on a fresh store.
        issue(2'd0, 32'd9, 1'b0);   wait_idle("idle_ins9");
        check("t1[9]=9", dut.table1[9], 9);
        check("count_1", count, 1);
        issue(2'd0, 32'd20, 1'b0);  wait_idle("idle_ins20");
        check("t2[1]=20", dut.table2[1], 20);
        check("count_2", count, 2);
        issue(2'd0, 32'd141, 1'b0); wait_idle("idle_ins141");
        check("t1[9]=141", dut.table1[9], 141);
        check("t2[0]=9", dut.table2[0], 9);
        check("t2[1]=20b", dut.table2[1], 20);
        check("count_3", count, 3);
        issue(2'd0, 32'd262, 1'b0); wait_idle("idle_ins262");
        check("fail_flag", resp_fail, 1);
        check("fail_key", resp_key, 141);
        check("fail_kicks", resp_kicks, 4);
        check("t1[9]=20", dut.table1[9], 20);
        check("t2[1]=262", dut.table2[1], 262);
        check("t2[0]=9b", dut.table2[0], 9);
        check("count_3b", count, 3);
        issue(2'd1, 32'd262, 1'b0);
        issue(2'd1, 32'd141, 1'b0);
        issue(2'd2, 32'd9, 1'b0);
        issue(2'd0, 32'd20, 1'b0);  wait_idle("idle_dir");
        check("dup_hit", resp_hit, 1);
        check("count_dup", count, 2);

        // Reset while the insert of 141 is inside its kick loop: no response may follow.
        @(negedge clk);
        req_op = 2'd0; req_key = 32'd141; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_mid_kick", req_ready, 0);
        reset_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        check("abort_ready", req_ready, 1);
        check("abort_count", count, 0);
        check("abort_resp_valid", resp_valid, 0);
        check_all_empty("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic over a small key pool to force collisions and kicks.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            issue((r < 50) ? 2'd0 : (r < 75) ? 2'd1 : (r < 96) ? 2'd2 : 2'd3,
                  KW'($urandom_range(0, 150)), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("idle_rand");
        check_tables();

        // CLEAR, then back-to-back ops with req_valid held through each busy period.
        issue(2'd0, 32'd5, 1'b1);
        issue(2'd3, 32'd0, 1'b1);  wait_idle("idle_clear");
        check("clear_count", count, 0);
        check_all_empty("clear");
        for (int n = 0; n < 6; n++) begin
            issue(2'(n % 3), KW'(n * 11 + 3), 1'b1);
        end
        wait_idle("idle_hold");
        repeat (5) @(negedge clk);
        check("resp_total", n_resp, n_issued);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
